gayle_host_xfer: RTL and testbench
==================================

Name:
gayle_host_xfer

Overview:
- Host-side transfer engine for the Gayle IDE data FIFO: the controller (SPI/host) end of the sector buffer.
- Serialises 16-bit FIFO words to a big-endian byte stream for the host (CPU-write direction), and packs host bytes into FIFO words (CPU-read direction).
- Counts 256-word sectors, gates each sector on FIFO occupancy, and cross-checks the FIFO's sector-boundary flags.

Parameters:
- SECT_W, 8, width of sector counter; max sectors per command = 2^SECT_W-1.
- GAP_CYC, 2, clk7_en cycles waited after a fifo_rd strobe before sampling fifo_data_out again (FIFO pointer update plus registered RAM read).

Ports:
- clk  in  1  bus clock.
- reset  in  1  synchronous, active-high reset.
- clk7_en  in  1  clock enable; all state, counters and outputs update only when high.
- cmd_start  in  1  start command (accepted in IDLE only).
- cmd_dir  in  1  0 = FIFO->host, 1 = host->FIFO; latched at start.
- cmd_sectors  in  SECT_W  sector count; latched at start.
- cmd_abort  in  1  abandon current command.
- host_rdy  out  1  byte available (dir 0) or byte accepted (dir 1).
- host_rd  in  1  host consumed host_dout.
- host_wr  in  1  host presents host_din.
- host_din  in  8  byte from host.
- host_dout  out  8  byte to host.
- fifo_data_out  in  16  FIFO read data.
- fifo_rd  out  1  FIFO read strobe.
- fifo_data_in  out  16  FIFO write data.
- fifo_wr  out  1  FIFO write strobe.
- fifo_full  in  1  at least one sector in FIFO.
- fifo_empty  in  1  FIFO empty.
- fifo_last_out  in  1  outgoing word is the last of its sector.
- fifo_last_in  in  1  incoming word is the last of its sector.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky boundary or protocol error.
- csum  out  16  running word checksum (see Optional Feature).

Behaviour:
- Reset or cmd_abort, in any state: enter IDLE.
  - busy, host_rdy, fifo_rd, fifo_wr, done = 0.
  - host_dout = 0, fifo_data_in = 0, word_cnt = 0, sect_cnt = 0.
  - Reset also clears err and csum; abort leaves them unchanged.
- All strobes (host_rd, host_wr, cmd_start) are sampled only on clk7_en cycles.
- fifo_rd, fifo_wr and done are registered and high for exactly one clk7_en period.
- IDLE + cmd_start:
  - cmd_sectors == 0: pulse done, stay IDLE.
  - Otherwise: latch dir and count, clear err, word_cnt = 0, busy = 1; go to TX_WAIT (dir 0) or RX_WAIT (dir 1).
  - cmd_start while busy is ignored.
- TX_WAIT: when !fifo_empty and (word_cnt != 0 or fifo_full):
  - latch word = fifo_data_out; host_dout = word[15:8]; host_rdy = 1 -> TX_HI.
- TX_HI + host_rd: host_dout = word[7:0] -> TX_LO.
- TX_LO + host_rd:
  - host_rdy = 0; pulse fifo_rd; word_cnt++ (8-bit, wraps 255 -> 0).
  - err is set if fifo_last_out != (word_cnt == 255).
  - At word 255: sect_cnt--; if this was the final sector -> DONE, else -> TX_GAP.
  - Not at word 255 -> TX_GAP.
- TX_GAP: hold GAP_CYC enabled cycles -> TX_WAIT.
- RX_WAIT:
  - At sector start (word_cnt == 0), wait for !fifo_full.
  - Then host_rdy = 1 -> RX_HI.
- RX_HI + host_wr: hi = host_din -> RX_LO.
- RX_LO + host_wr:
  - fifo_data_in = {hi, host_din}; pulse fifo_wr; word_cnt++.
  - err is set if fifo_last_in != (word_cnt == 255).
  - At word 255: host_rdy = 0; sect_cnt--; if final sector -> DONE, else -> RX_WAIT.
  - Otherwise -> RX_HI with host_rdy held at 1.
- DONE: pulse done; busy = 0; host_rdy = 0 -> IDLE.
- Protocol errors:
  - host_rd while host_rdy = 0 or dir = 1: ignored, and sets err.
  - host_wr while host_rdy = 0 or dir = 0: ignored, and sets err.
  - host_rd and host_wr together: both ignored, and sets err.
- Byte order is always high byte first.

Optional Feature:
- Macro GAYLE_HOST_CSUM_EN.
- Defined: csum = 16-bit wrap-around sum of every word written to or read from the FIFO. Cleared on cmd_start and on reset. Updated on the cycle of each fifo_rd or fifo_wr pulse.
- Undefined: csum is tied to 0 and no adder is built.

Test Plan:
- dir 0, 1 sector; FIFO preloaded with 0x0000..0x00FF; fifo_full = 1 -> host receives 512 bytes 00 00 00 01 .. 00 FF, 256 fifo_rd pulses, done once, err = 0.
- dir 1, 2 sectors; host writes bytes 0xA5, 0x5A repeated -> 512 fifo_wr pulses of 0xA55A. Second sector starts only after fifo_full deasserts. done once.
- dir 0, 1 sector; fifo_last_out forced 1 at word 10 -> err = 1 after word 10; transfer still completes with 256 reads and done.
- Abort at word 100 of dir 1 -> IDLE on next enabled cycle, busy = 0, no done, no further fifo_wr. A following cmd_start is accepted.
- cmd_sectors = 0 -> done pulse, busy never set. host_rd in IDLE -> err = 1, no fifo_rd.
- GAYLE_HOST_CSUM_EN defined: dir 1 transfer of 256 words of 0x0101 -> csum = 0x0100 at done. Undefined -> csum = 0.

Source files
------------

// File: rtl/gayle_host_xfer.sv
`timescale 1ns/1ps
// Host-side Gayle IDE sector-buffer transfer engine (byte <-> word, sector gating).
// Optional running word checksum enabled by defining GAYLE_HOST_CSUM_EN.
module gayle_host_xfer #(
    parameter int SECT_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk7_en,
    input  logic              cmd_start,
    input  logic              cmd_dir,
    input  logic [SECT_W-1:0] cmd_sectors,
    input  logic              cmd_abort,
    output logic              host_rdy,
    input  logic              host_rd,
    input  logic              host_wr,
    input  logic [7:0]        host_din,
    output logic [7:0]        host_dout,
    input  logic [15:0]       fifo_data_out,
    output logic              fifo_rd,
    output logic [15:0]       fifo_data_in,
    output logic              fifo_wr,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              fifo_last_out,
    input  logic              fifo_last_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       csum
);

    typedef enum logic [3:0] {
        S_IDLE, S_TX_WAIT, S_TX_HI, S_TX_LO, S_TX_GAP,
        S_RX_WAIT, S_RX_HI, S_RX_LO, S_DONE
    } state_t;

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    state_t            state, state_nx;
    logic              dir, dir_nx;
    logic [SECT_W-1:0] sect_cnt, sect_nx;
    logic [7:0]        word_cnt, word_cnt_nx;
    logic [15:0]       word, word_nx;
    logic [7:0]        hi, hi_nx;
    logic [GW-1:0]     gap, gap_nx;
    logic              host_rdy_nx, fifo_rd_nx, fifo_wr_nx;
    logic              busy_nx, done_nx, err_nx;
    logic [7:0]        host_dout_nx;
    logic [15:0]       fifo_data_in_nx;
    logic              rd_ok, wr_ok, proto_err;
    logic              last_word, final_sect;

    // A strobe is only legal when the engine offers a byte in the matching direction.
    assign rd_ok      = host_rd && !host_wr && host_rdy && !dir;
    assign wr_ok      = host_wr && !host_rd && host_rdy && dir;
    assign proto_err  = (host_rd && !rd_ok) || (host_wr && !wr_ok);
    assign last_word  = (word_cnt == 8'hFF);
    assign final_sect = (sect_cnt == SECT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            dir          <= 1'b0;
            sect_cnt     <= '0;
            word_cnt     <= '0;
            word         <= '0;
            hi           <= '0;
            gap          <= '0;
            host_rdy     <= 1'b0;
            host_dout    <= '0;
            fifo_rd      <= 1'b0;
            fifo_wr      <= 1'b0;
            fifo_data_in <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else if (clk7_en) begin
            state        <= state_nx;
            dir          <= dir_nx;
            sect_cnt     <= sect_nx;
            word_cnt     <= word_cnt_nx;
            word         <= word_nx;
            hi           <= hi_nx;
            gap          <= gap_nx;
            host_rdy     <= host_rdy_nx;
            host_dout    <= host_dout_nx;
            fifo_rd      <= fifo_rd_nx;
            fifo_wr      <= fifo_wr_nx;
            fifo_data_in <= fifo_data_in_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            err          <= err_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        dir_nx          = dir;
        sect_nx         = sect_cnt;
        word_cnt_nx     = word_cnt;
        word_nx         = word;
        hi_nx           = hi;
        gap_nx          = gap;
        host_rdy_nx     = host_rdy;
        host_dout_nx    = host_dout;
        fifo_data_in_nx = fifo_data_in;
        busy_nx         = busy;
        err_nx          = err;
        fifo_rd_nx      = 1'b0;
        fifo_wr_nx      = 1'b0;
        done_nx         = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cmd_sectors == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        dir_nx      = cmd_dir;
                        sect_nx     = cmd_sectors;
                        err_nx      = 1'b0;
                        word_cnt_nx = '0;
                        busy_nx     = 1'b1;
                        state_nx    = cmd_dir ? S_RX_WAIT : S_TX_WAIT;
                    end
                end
            end
            S_TX_WAIT: begin
                // A new sector may only start once a whole sector is buffered.
                if (!fifo_empty && (word_cnt != 8'd0 || fifo_full)) begin
                    word_nx      = fifo_data_out;
                    host_dout_nx = fifo_data_out[15:8];
                    host_rdy_nx  = 1'b1;
                    state_nx     = S_TX_HI;
                end
            end
            S_TX_HI: begin
                if (rd_ok) begin
                    host_dout_nx = word[7:0];
                    state_nx     = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (rd_ok) begin
                    host_rdy_nx = 1'b0;
                    fifo_rd_nx  = 1'b1;
                    word_cnt_nx = word_cnt + 8'd1;
                    gap_nx      = '0;
                    if (fifo_last_out != last_word) err_nx = 1'b1;
                    state_nx = S_TX_GAP;
                    if (last_word) begin
                        sect_nx = sect_cnt - SECT_W'(1);
                        if (final_sect) state_nx = S_DONE;
                    end
                end
            end
            S_TX_GAP: begin
                if (gap == GAP_LAST) state_nx = S_TX_WAIT;
                else gap_nx = gap + GW'(1);
            end
            S_RX_WAIT: begin
                if (word_cnt != 8'd0 || !fifo_full) begin
                    host_rdy_nx = 1'b1;
                    state_nx    = S_RX_HI;
                end
            end
            S_RX_HI: begin
                if (wr_ok) begin
                    hi_nx    = host_din;
                    state_nx = S_RX_LO;
                end
            end
            S_RX_LO: begin
                if (wr_ok) begin
                    fifo_data_in_nx = {hi, host_din};
                    fifo_wr_nx      = 1'b1;
                    word_cnt_nx     = word_cnt + 8'd1;
                    if (fifo_last_in != last_word) err_nx = 1'b1;
                    state_nx = S_RX_HI;
                    if (last_word) begin
                        host_rdy_nx = 1'b0;
                        sect_nx     = sect_cnt - SECT_W'(1);
                        state_nx    = final_sect ? S_DONE : S_RX_WAIT;
                    end
                end
            end
            S_DONE: begin
                done_nx     = 1'b1;
                busy_nx     = 1'b0;
                host_rdy_nx = 1'b0;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (proto_err) err_nx = 1'b1;

        if (cmd_abort) begin
            state_nx        = S_IDLE;
            busy_nx         = 1'b0;
            host_rdy_nx     = 1'b0;
            fifo_rd_nx      = 1'b0;
            fifo_wr_nx      = 1'b0;
            done_nx         = 1'b0;
            host_dout_nx    = '0;
            fifo_data_in_nx = '0;
            word_cnt_nx     = '0;
            sect_nx         = '0;
            err_nx          = err;
        end
    end

`ifdef GAYLE_HOST_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (clk7_en) begin
            if (state == S_IDLE && cmd_start && !cmd_abort) csum_q <= '0;
            else if (fifo_rd_nx) csum_q <= csum_q + word;
            else if (fifo_wr_nx) csum_q <= csum_q + fifo_data_in_nx;
        end
    end

    assign csum = csum_q;
`else
    assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_gayle_host_xfer.sv
`timescale 1ns/1ps
// Directed bench for gayle_host_xfer: TX/RX sectors, gating, errors, abort.
module tb_gayle_host_xfer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk7_en = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_sectors = 8'd0;
    logic        cmd_abort = 1'b0;
    logic        host_rdy;
    logic        host_rd = 1'b0;
    logic        host_wr = 1'b0;
    logic [7:0]  host_din = 8'd0;
    logic [7:0]  host_dout;
    logic [15:0] fifo_data_out;
    logic        fifo_rd;
    logic [15:0] fifo_data_in;
    logic        fifo_wr;
    logic        fifo_full = 1'b0;
    logic        fifo_empty;
    logic        fifo_last_out;
    logic        fifo_last_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] csum;

    logic [15:0] mem [256];
    int          rp = 0;
    int          nwords = 0;
    int          force_at = -1;
    int          wcnt = 0;
    logic [15:0] wexp = 16'h0;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_bad = 0;
    int done_cnt = 0;

    localparam int LIM = 100;

`ifdef GAYLE_HOST_CSUM_EN
    localparam logic [15:0] CS_TX  = 16'h7F80;
    localparam logic [15:0] CS_RX2 = 16'hB400;
    localparam logic [15:0] CS_RX1 = 16'h0100;
`else
    localparam logic [15:0] CS_TX  = 16'h0000;
    localparam logic [15:0] CS_RX2 = 16'h0000;
    localparam logic [15:0] CS_RX1 = 16'h0000;
`endif

    gayle_host_xfer dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .cmd_start(cmd_start), .cmd_dir(cmd_dir),
        .cmd_sectors(cmd_sectors), .cmd_abort(cmd_abort),
        .host_rdy(host_rdy), .host_rd(host_rd), .host_wr(host_wr),
        .host_din(host_din), .host_dout(host_dout),
        .fifo_data_out(fifo_data_out), .fifo_rd(fifo_rd),
        .fifo_data_in(fifo_data_in), .fifo_wr(fifo_wr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_last_out(fifo_last_out), .fifo_last_in(fifo_last_in),
        .busy(busy), .done(done), .err(err), .csum(csum)
    );

    always #5 clk = ~clk;

    assign fifo_data_out = mem[rp[7:0]];
    assign fifo_empty    = (rp >= nwords);
    assign fifo_last_out = (rp[7:0] == 8'hFF) || (rp == force_at);
    assign fifo_last_in  = (wcnt[7:0] == 8'hFF);

    always @(posedge clk) begin
        if (clk7_en && fifo_rd) rd_cnt <= rd_cnt + 1;
        if (clk7_en && fifo_wr) wr_cnt <= wr_cnt + 1;
        if (clk7_en && fifo_wr && fifo_data_in != wexp) wr_bad <= wr_bad + 1;
        if (clk7_en && done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic start(input logic d, input logic [7:0] s);
        cmd_dir = d;
        cmd_sectors = s;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!host_rdy && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n == LIM) chk("rdy_timeout", {31'd0, host_rdy}, 32'd1);
    endtask

    task automatic tx_word(output logic [15:0] w);
        logic [7:0] b;
        wait_rdy();
        b = host_dout;
        host_rd = 1'b1;
        @(negedge clk);
        w = {b, host_dout};
        @(negedge clk);
        host_rd = 1'b0;
        rp++;
    endtask

    task automatic rx_word(input logic [15:0] w);
        host_wr = 1'b0;
        wait_rdy();
        host_wr = 1'b1;
        host_din = w[15:8];
        @(negedge clk);
        host_din = w[7:0];
        @(negedge clk);
        host_wr = 1'b0;
        wcnt++;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        cyc(2);
        chk("done_once", done_cnt - d0, 1);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask

    initial begin
        logic [15:0] w;
        int r0, w0, d0;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        cyc(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rdy", {31'd0, host_rdy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_dout", {24'd0, host_dout}, 0);
        chk("rst_csum", {16'd0, csum}, 0);
        chk("rst_strobes", {30'd0, fifo_rd, fifo_wr}, 0);

        // cmd_start ignored while the clock enable is low
        clk7_en = 1'b0;
        cmd_sectors = 8'd1;
        cmd_start = 1'b1;
        cyc(3);
        cmd_start = 1'b0;
        clk7_en = 1'b1;
        @(negedge clk);
        chk("en_gate_busy", {31'd0, busy}, 0);

        // FIFO->host, one sector of 0x0000..0x00FF
        rp = 0; nwords = 256; fifo_full = 1'b1;
        r0 = rd_cnt; d0 = done_cnt;
        start(1'b0, 8'd1);
        chk("tx_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 256; i++) begin
            tx_word(w);
            if (i < 3 || i > 252) chk("tx_word", {16'd0, w}, 32'(i));
            else if (w != 16'(i)) chk("tx_word", {16'd0, w}, 32'(i));
        end
        wait_done(d0);
        chk("tx_reads", rd_cnt - r0, 256);
        chk("tx_err", {31'd0, err}, 0);
        chk("tx_csum", {16'd0, csum}, {16'd0, CS_TX});

        // host->FIFO, two sectors of 0xA55A with full-gating between
        wcnt = 0; wexp = 16'hA55A; fifo_full = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        start(1'b1, 8'd2);
        for (int i = 0; i < 256; i++) rx_word(16'hA55A);
        fifo_full = 1'b1;
        cyc(6);
        chk("rx_gate_rdy", {31'd0, host_rdy}, 0);
        chk("rx_gate_wr", wr_cnt - w0, 256);
        fifo_full = 1'b0;
        for (int i = 0; i < 256; i++) rx_word(16'hA55A);
        wait_done(d0);
        chk("rx_writes", wr_cnt - w0, 512);
        chk("rx_data_bad", wr_bad, 0);
        chk("rx_err", {31'd0, err}, 0);
        chk("rx_csum", {16'd0, csum}, {16'd0, CS_RX2});

        // FIFO->host with a spurious last flag at word 10
        rp = 0; nwords = 256; fifo_full = 1'b1; force_at = 10;
        r0 = rd_cnt; d0 = done_cnt;
        start(1'b0, 8'd1);
        for (int i = 0; i < 10; i++) tx_word(w);
        chk("last_err_before", {31'd0, err}, 0);
        tx_word(w);
        chk("last_err_after", {31'd0, err}, 1);
        for (int i = 11; i < 256; i++) tx_word(w);
        wait_done(d0);
        chk("last_reads", rd_cnt - r0, 256);
        chk("last_err_sticky", {31'd0, err}, 1);
        force_at = -1;

        // abort in the middle of a host->FIFO sector
        wcnt = 0; wexp = 16'h1234; fifo_full = 1'b0;
        w0 = wr_cnt;
        start(1'b1, 8'd1);
        for (int i = 0; i < 100; i++) rx_word(16'h1234);
        d0 = done_cnt;
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_rdy", {31'd0, host_rdy}, 0);
        cyc(10);
        chk("abort_writes", wr_cnt - w0, 100);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_err", {31'd0, err}, 0);
        start(1'b1, 8'd1);
        chk("restart_busy", {31'd0, busy}, 1);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        @(negedge clk);

        // zero-sector command and a stray host_rd in IDLE
        r0 = rd_cnt;
        start(1'b0, 8'd0);
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("zero_done_pulse", {31'd0, done}, 0);
        chk("zero_err_clear", {31'd0, err}, 0);
        host_rd = 1'b1;
        @(negedge clk);
        host_rd = 1'b0;
        cyc(2);
        chk("idle_rd_err", {31'd0, err}, 1);
        chk("idle_rd_noread", rd_cnt - r0, 0);

        // checksum over one sector of 0x0101
        wcnt = 0; wexp = 16'h0101; fifo_full = 1'b0;
        d0 = done_cnt;
        start(1'b1, 8'd1);
        chk("cs_err_cleared", {31'd0, err}, 0);
        for (int i = 0; i < 256; i++) rx_word(16'h0101);
        wait_done(d0);
        chk("cs_value", {16'd0, csum}, {16'd0, CS_RX1});
        chk("cs_data_bad", wr_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
